// File: rtl/issue_queue_nw_pkg.sv
// Shared issue-queue types and default geometry.
// Imported by the interface and the queue top.
package issue_queue_nw_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;
    localparam int ISSUE_NUM        = 2;
    localparam int DECODE_NUM       = 2;
    localparam int INSTR_INFO_W     = 128;

    typedef logic [INSTR_INFO_W-1:0] instr_info_t;

    typedef struct packed {
        logic        valid;
        instr_info_t instr_info;
    } issue_entry_t;

endpackage

// File: rtl/issue_queue_nw_if.sv
// Decode->issue-queue->issue bundle: enqueue group, head window, fire/stall/flush, status.
// Queue side is the slave; the master drives requests and consumes the head window.
interface issue_queue_nw_if
    import issue_queue_nw_pkg::*;
#(
    parameter int  DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int  ENQ_W   = DECODE_NUM,
    parameter int  ISSUE_W = ISSUE_NUM,
    parameter int  DATA_W  = INSTR_INFO_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
);
    logic                      flush;
    logic                      stall;
    logic [ENQ_W-1:0]          in_valid;
    logic [ENQ_W*DATA_W-1:0]   in_data;
    logic                      in_ready;
    logic [ISSUE_W-1:0]        out_valid;
    logic [ISSUE_W*DATA_W-1:0] out_data;
    logic [ISSUE_W-1:0]        out_fire;
    logic [CNT_W-1:0]          count;
    logic                      empty;
    logic                      full;

    modport master (
        output flush, stall, in_valid, in_data, out_fire,
        input  in_ready, out_valid, out_data, count, empty, full
    );

    modport slave (
        input  flush, stall, in_valid, in_data, out_fire,
        output in_ready, out_valid, out_data, count, empty, full
    );
endinterface

// File: rtl/issue_queue_nw_prefix_ones_count.sv
// Length of the run of ones starting at bit 0; purely combinational.
module issue_queue_nw_prefix_ones_count #(
    parameter int  W  = 2,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] ones
);
    // ones only equals i while every lower bit has been set
    always_comb begin
        ones = '0;
        for (int i = 0; i < W; i++) begin
            if (bits[i] && (ones == CW'(i))) ones = CW'(i + 1);
        end
    end
endmodule

// File: rtl/issue_queue_nw.sv
// In-order issue queue: up to ENQ_W writes per cycle, oldest ISSUE_W entries as head window.
// Latency one cycle (no bypass); in_ready only from registered free space, prefix retire of the window.
module issue_queue_nw
    import issue_queue_nw_pkg::*;
#(
    parameter int  DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int  ENQ_W   = DECODE_NUM,
    parameter int  ISSUE_W = ISSUE_NUM,
    parameter int  DATA_W  = INSTR_INFO_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             resetn,
    issue_queue_nw_if.slave q
);
    localparam int ENQ_CW = $clog2(ENQ_W + 1);
    localparam int DEQ_CW = $clog2(ISSUE_W + 1);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   ent_vld, ent_vld_nxt;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count_q, n_enq, n_deq;
    logic [ENQ_CW-1:0]  enq_run;
    logic [DEQ_CW-1:0]  deq_run;
    logic [ISSUE_W-1:0] win_vld;
    logic               ready;

    // DEPTH may be non power of two, so wrap by compare-and-subtract on one extra bit
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    issue_queue_nw_prefix_ones_count #(.W(ENQ_W))   u_enq_cnt (.bits(q.in_valid),           .ones(enq_run));
    issue_queue_nw_prefix_ones_count #(.W(ISSUE_W)) u_deq_cnt (.bits(q.out_fire & win_vld), .ones(deq_run));

    assign ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_W);
    assign n_enq = ready   ? CNT_W'(enq_run) : '0;
    assign n_deq = q.stall ? '0 : CNT_W'(deq_run);

    always_comb begin
        q.out_data = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            win_vld[k] = CNT_W'(k) < count_q;
            if (win_vld[k]) q.out_data[k*DATA_W +: DATA_W] = mem[wrap_add(head, CNT_W'(k))];
        end
    end

    always_comb begin
        ent_vld_nxt = ent_vld;
        for (int k = 0; k < ISSUE_W; k++)
            if (CNT_W'(k) < n_deq) ent_vld_nxt[wrap_add(head, CNT_W'(k))] = 1'b0;
        for (int i = 0; i < ENQ_W; i++)
            if (CNT_W'(i) < n_enq) ent_vld_nxt[wrap_add(tail, CNT_W'(i))] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ent_vld <= '0;
        end else if (q.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            ent_vld <= '0;
        end else begin
            head    <= wrap_add(head, n_deq);
            tail    <= wrap_add(tail, n_enq);
            count_q <= count_q + n_enq - n_deq;
            ent_vld <= ent_vld_nxt;
        end
    end

    // Payload storage carries no reset; the window masks anything not yet written
    always_ff @(posedge clk) begin
        if (!q.flush) begin
            for (int i = 0; i < ENQ_W; i++)
                if (CNT_W'(i) < n_enq) mem[wrap_add(tail, CNT_W'(i))] <= q.in_data[i*DATA_W +: DATA_W];
        end
    end

    assign q.in_ready  = ready;
    assign q.out_valid = win_vld;
    assign q.count     = count_q;
    assign q.empty     = count_q == '0;
    assign q.full      = count_q == CNT_W'(DEPTH);

    a_count_max: assert property (@(posedge clk) disable iff (!resetn) count_q <= CNT_W'(DEPTH));
    a_ptr_gap:   assert property (@(posedge clk) disable iff (!resetn)
                     ((int'(tail) - int'(head) + DEPTH) % DEPTH) == (int'(count_q) % DEPTH));
    a_deq_le:    assert property (@(posedge clk) disable iff (!resetn) n_deq <= count_q);
    a_vld_bits:  assert property (@(posedge clk) disable iff (!resetn) $countones(ent_vld) == int'(count_q));
endmodule

// File: tb/tb_issue_queue_nw.sv
// Drives a DEPTH=8 and a DEPTH=6 queue with identical stimulus and checks both against queue models.
module tb_issue_queue_nw;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0, stall = 1'b0;
    logic [1:0] in_valid = '0, out_fire = '0;
    logic [2*DW-1:0] in_data = '0;
    int tests_run = 0, fails = 0;
    logic [DW-1:0] m8[$], m6[$];

    issue_queue_nw_if #(.DEPTH(8), .ENQ_W(2), .ISSUE_W(2), .DATA_W(DW)) if8 ();
    issue_queue_nw_if #(.DEPTH(6), .ENQ_W(2), .ISSUE_W(2), .DATA_W(DW)) if6 ();

    assign if8.flush = flush;  assign if8.stall = stall;  assign if8.in_valid = in_valid;
    assign if8.in_data = in_data;  assign if8.out_fire = out_fire;
    assign if6.flush = flush;  assign if6.stall = stall;  assign if6.in_valid = in_valid;
    assign if6.in_data = in_data;  assign if6.out_fire = out_fire;

    issue_queue_nw #(.DEPTH(8), .ENQ_W(2), .ISSUE_W(2), .DATA_W(DW)) dut8 (.clk(clk), .resetn(resetn), .q(if8));
    issue_queue_nw #(.DEPTH(6), .ENQ_W(2), .ISSUE_W(2), .DATA_W(DW)) dut6 (.clk(clk), .resetn(resetn), .q(if6));

    always #5 clk = ~clk;

    function automatic int lead_ones(input logic [1:0] b);
        int n = 0;
        while (n < 2 && b[n]) n++;
        return n;
    endfunction

    function automatic logic [1:0] exp_vld(input int sz);
        return {sz > 1, sz > 0};
    endfunction

    // Model update uses pre-edge occupancy, then the edge is taken and outputs sampled 1ns later
    task automatic tick();
        int ne, nd;
        ne = ((8 - m8.size()) >= 2) ? lead_ones(in_valid) : 0;
        nd = stall ? 0 : lead_ones(out_fire & exp_vld(m8.size()));
        if (flush) m8.delete();
        else begin
            repeat (nd) void'(m8.pop_front());
            for (int i = 0; i < ne; i++) m8.push_back(in_data[i*DW +: DW]);
        end
        ne = ((6 - m6.size()) >= 2) ? lead_ones(in_valid) : 0;
        nd = stall ? 0 : lead_ones(out_fire & exp_vld(m6.size()));
        if (flush) m6.delete();
        else begin
            repeat (nd) void'(m6.pop_front());
            for (int i = 0; i < ne; i++) m6.push_back(in_data[i*DW +: DW]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; stall = 0; in_valid = '0; out_fire = '0; in_data = '0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (if8.count !== 4'd0 || if8.empty !== 1'b1 || if8.full !== 1'b0) begin fails++; $display("FAIL reset_status count=%0d empty=%b full=%b want 0/1/0", if8.count, if8.empty, if8.full); end
        tests_run++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 2'b00 || if8.out_data !== '0) begin fails++; $display("FAIL reset_window rdy=%b vld=%b dat=%h want 1/00/0", if8.in_ready, if8.out_valid, if8.out_data); end
        #5 resetn = 1;
        @(posedge clk); #1;
        in_valid = 2'b11; in_data = {32'h11, 32'h10}; tick();
        in_data = {32'h13, 32'h12}; tick();
        in_valid = 2'b01; in_data = {32'h0, 32'h14}; tick();
        idle();
        tests_run++; if (if8.count !== 4'd5) begin fails++; $display("FAIL preload_count got %0d want 5", if8.count); end
        #2 resetn = 0;
        #1;
        tests_run++; if (if8.count !== 4'd0 || if8.out_valid !== 2'b00 || if8.in_ready !== 1'b1) begin fails++; $display("FAIL async_reset count=%0d vld=%b rdy=%b want 0/00/1", if8.count, if8.out_valid, if8.in_ready); end
        tests_run++; if (if6.count !== 3'd0 || if6.empty !== 1'b1) begin fails++; $display("FAIL async_reset6 count=%0d empty=%b want 0/1", if6.count, if6.empty); end
        #1 resetn = 1;
        m8.delete(); m6.delete();
    endtask

    task automatic test_fill();
        for (int g = 0; g < 4; g++) begin
            in_valid = 2'b11;
            in_data = {32'hA000_0000 + 32'(2*g+1), 32'hA000_0000 + 32'(2*g)};
            tick();
            if (g == 2) begin
                tests_run++; if (if6.count !== 3'd6 || if6.in_ready !== 1'b0 || if6.full !== 1'b1) begin fails++; $display("FAIL fill6_edge3 count=%0d rdy=%b full=%b want 6/0/1", if6.count, if6.in_ready, if6.full); end
                tests_run++; if (if8.count !== 4'd6 || if8.in_ready !== 1'b1) begin fails++; $display("FAIL fill8_edge3 count=%0d rdy=%b want 6/1", if8.count, if8.in_ready); end
            end
        end
        idle();
        tests_run++; if (if6.count !== 3'd6 || if6.out_data !== {32'hA000_0001, 32'hA000_0000}) begin fails++; $display("FAIL fill6_hold count=%0d dat=%h want 6/a0000001a0000000", if6.count, if6.out_data); end
        tests_run++; if (if8.count !== 4'd8 || if8.full !== 1'b1 || if8.in_ready !== 1'b0) begin fails++; $display("FAIL fill8_full count=%0d full=%b rdy=%b want 8/1/0", if8.count, if8.full, if8.in_ready); end
        flush = 1; tick(); idle();
    endtask

    task automatic test_partial_issue();
        in_valid = 2'b11; in_data = {32'hB1, 32'hB0}; tick();
        in_valid = 2'b01; in_data = {32'h0, 32'hB2}; tick();
        in_valid = 2'b00; out_fire = 2'b01; tick();
        tests_run++; if (if8.count !== 4'd2 || if8.out_data !== {32'hB2, 32'hB1}) begin fails++; $display("FAIL partial_01 count=%0d dat=%h want 2/000000b2000000b1", if8.count, if8.out_data); end
        out_fire = 2'b10; tick();
        tests_run++; if (if8.count !== 4'd2 || if6.count !== 3'd2 || if8.out_data !== {32'hB2, 32'hB1}) begin fails++; $display("FAIL partial_gap count8=%0d count6=%0d dat=%h want 2/2/000000b2000000b1", if8.count, if6.count, if8.out_data); end
        idle(); flush = 1; tick(); idle();
    endtask

    task automatic test_wrap();
        int nxt_in = 0, nxt_out = 0;
        in_valid = 2'b11; in_data = {32'(nxt_in + 1), 32'(nxt_in)}; nxt_in += 2; tick();
        for (int c = 0; c < 10; c++) begin
            in_valid = 2'b11; out_fire = 2'b11;
            in_data = {32'(nxt_in + 1), 32'(nxt_in)}; nxt_in += 2;
            tick();
            nxt_out += 2;
            tests_run++; if (if6.count !== 3'd2 || if6.out_data !== {32'(nxt_out + 1), 32'(nxt_out)}) begin fails++; $display("FAIL wrap6_c%0d count=%0d dat=%h want 2/%h", c, if6.count, if6.out_data, {32'(nxt_out + 1), 32'(nxt_out)}); end
            tests_run++; if (if8.out_data !== {m8[1], m8[0]}) begin fails++; $display("FAIL wrap8_c%0d dat=%h want %h", c, if8.out_data, {m8[1], m8[0]}); end
        end
        idle(); flush = 1; tick(); idle();
    endtask

    task automatic test_stall_flush();
        in_valid = 2'b11; in_data = {32'hC1, 32'hC0}; tick();
        in_valid = 2'b01; in_data = {32'h0, 32'hC2}; tick();
        in_valid = 2'b00; stall = 1; out_fire = 2'b11; tick();
        tests_run++; if (if8.count !== 4'd3 || if8.out_data !== {32'hC1, 32'hC0}) begin fails++; $display("FAIL stall_hold count=%0d dat=%h want 3/000000c1000000c0", if8.count, if8.out_data); end
        stall = 0; flush = 1; in_valid = 2'b11; in_data = {32'hD1, 32'hD0}; tick();
        tests_run++; if (if8.count !== 4'd0 || if8.empty !== 1'b1 || if8.out_valid !== 2'b00 || if8.out_data !== '0) begin fails++; $display("FAIL flush_clear count=%0d empty=%b vld=%b dat=%h want 0/1/00/0", if8.count, if8.empty, if8.out_valid, if8.out_data); end
        idle(); tick();
        tests_run++; if (if8.count !== 4'd0 || if6.count !== 3'd0) begin fails++; $display("FAIL flush_drop count8=%0d count6=%0d want 0/0", if8.count, if6.count); end
    endtask

    task automatic test_single();
        in_valid = 2'b01; in_data = {32'hFFFF_FFFF, 32'hE0}; tick();
        tests_run++; if (if8.count !== 4'd1 || if8.out_valid !== 2'b01 || if8.out_data !== {32'h0, 32'hE0}) begin fails++; $display("FAIL single_load count=%0d vld=%b dat=%h want 1/01/00000000000000e0", if8.count, if8.out_valid, if8.out_data); end
        in_valid = 2'b00; out_fire = 2'b11; tick();
        tests_run++; if (if8.count !== 4'd0 || if8.empty !== 1'b1 || if6.count !== 3'd0) begin fails++; $display("FAIL single_issue count8=%0d empty=%b count6=%0d want 0/1/0", if8.count, if8.empty, if6.count); end
        idle();
    endtask

    task automatic test_random();
        logic [1:0] v;
        for (int c = 0; c < 400; c++) begin
            v = 2'($urandom_range(0, 3));
            in_valid = v;
            in_data = {$urandom, $urandom};
            out_fire = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
            tests_run++; if (int'(if8.count) !== m8.size() || if8.in_ready !== ((8 - m8.size()) >= 2) || if8.full !== (m8.size() == 8) || if8.empty !== (m8.size() == 0)) begin fails++; $display("FAIL rand8_state c=%0d count=%0d rdy=%b full=%b empty=%b want count %0d", c, if8.count, if8.in_ready, if8.full, if8.empty, m8.size()); end
            tests_run++; if (if8.out_valid !== exp_vld(m8.size()) || if8.out_data !== {(m8.size() > 1) ? m8[1] : 32'h0, (m8.size() > 0) ? m8[0] : 32'h0}) begin fails++; $display("FAIL rand8_window c=%0d vld=%b dat=%h size %0d", c, if8.out_valid, if8.out_data, m8.size()); end
            tests_run++; if (int'(if6.count) !== m6.size() || if6.in_ready !== ((6 - m6.size()) >= 2) || if6.full !== (m6.size() == 6) || if6.empty !== (m6.size() == 0)) begin fails++; $display("FAIL rand6_state c=%0d count=%0d rdy=%b full=%b empty=%b want count %0d", c, if6.count, if6.in_ready, if6.full, if6.empty, m6.size()); end
            tests_run++; if (if6.out_valid !== exp_vld(m6.size()) || if6.out_data !== {(m6.size() > 1) ? m6[1] : 32'h0, (m6.size() > 0) ? m6[0] : 32'h0}) begin fails++; $display("FAIL rand6_window c=%0d vld=%b dat=%h size %0d", c, if6.out_valid, if6.out_data, m6.size()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_partial_issue();
        test_wrap();
        test_stall_flush();
        test_single();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
